norm_unit: RTL and testbench
============================

# norm_unit

Iterative normalizer: the inverse operation of the datapath's funnel shifter. It accepts a 16-bit word and shifts it left one bit per cycle until it is normalized. It returns the normalized word plus the shift count, so a later funnel-shifter pass can denormalize with that count. It sits beside the shifter in the execute stage and serves CLZ/CLS-style instructions and fixed-point normalization. Both sides use valid/ready handshakes.

## Interface
Parameters: none (width fixed at 16).

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_data  in  16  word to normalize
- in_signed  in  1  0: unsigned normalize (leading zeros); 1: signed normalize (redundant sign bits)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  16  normalized word
- out_count  out  5  left-shift amount applied, 0..16
- out_zero  out  1  input was 0x0000

## Operation
- State machine: IDLE, SHIFT, DONE. Reset: state IDLE; data/count/flag registers 0; out_valid 0; in_ready 1.
- in_ready = (state == IDLE). out_valid = (state == DONE). Both are pure decodes of state.
- IDLE, when in_valid && in_ready:
  - Latch in_data into the work register and latch in_signed.
  - Clear count.
  - If in_data == 0x0000: set zero flag, count = 16 (unsigned) or 15 (signed), work register 0, and go to DONE.
  - Otherwise go to SHIFT.
- SHIFT, each cycle, evaluates the normalized condition:
  - Unsigned: work[15] == 1.
  - Signed: work[15] != work[14].
  - If the condition holds, go to DONE and leave the work register untouched.
  - Otherwise shift work left by 1, inserting 0 at bit 0, and increment count.
- Maximum counts:
  - Nonzero unsigned input reaches the condition within 15 shifts.
  - Signed 0xFFFF reaches 0x8000 after 15 shifts.
  - Count never exceeds 15 in SHIFT. A count of 16 occurs only on the zero path.
- DONE: outputs are driven from registers and held stable while out_ready is low. When out_ready is high, go to IDLE.
- No bypass. A new request cannot be accepted in the cycle the result is consumed; in_ready rises the next cycle.
- Inputs in_data and in_signed are don't-care outside the accepting cycle.
- Asserting rst_n low in any state returns immediately to IDLE with reset values. Any in-flight result is discarded and never appears on out_valid.

## Timing
- Accept cycle T (in_valid && in_ready sampled high at edge ending T).
- Nonzero input: out_valid is high in cycle T+2+count. Minimum latency 2 (count 0); maximum 17 (count 15).
- Zero input: out_valid is high in cycle T+1.
- The result is consumed at the first edge where out_valid && out_ready. in_ready is high in the following cycle.
- Sustained throughput is one op per count+3 cycles for nonzero inputs, or 2 cycles for zero, with out_ready held high.
- out_data, out_count and out_zero change only on the SHIFT→DONE or IDLE→DONE transition, or on reset.

## Test plan
- Unsigned 0x8000 -> out_data 0x8000, count 0, zero 0, out_valid at T+2.
- Unsigned 0x0001 -> out_data 0x8000, count 15, zero 0, out_valid at T+17.
- Signed 0xFFF0 -> out_data 0x8000, count 11.
- Signed 0x0003 -> out_data 0x6000, count 13.
- Signed 0xFFFF -> out_data 0x8000, count 15.
- Zero input:
  - Unsigned 0x0000 -> out_data 0, count 16, zero 1, out_valid at T+1.
  - Signed 0x0000 -> count 15, zero 1.
- Backpressure: unsigned 0x0100 with out_ready low for 5 cycles after out_valid.
  - out_data 0x8000 and count 7 hold stable; in_ready stays 0.
  - After out_ready goes high, in_ready returns to 1 the next cycle and back-to-back requests are accepted.
- Reset mid-SHIFT: apply rst_n low 3 cycles after accepting 0x0001.
  - out_valid and state clear immediately, in_ready reads 1.
  - No stale result appears after rst_n is released.

Source files
------------

// File: rtl/norm_unit_if.sv
// norm_unit_if: request/result handshake bundle for the iterative normalizer.
//   Request side : in_valid, in_ready, in_data[15:0], in_signed
//   Result side  : out_valid, out_ready, out_data[15:0], out_count[4:0], out_zero
// Modports:
//   master - the requester/consumer (drives requests, accepts results)
//   slave  - the normalizer itself
interface norm_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [4:0]  out_count;
  logic        out_zero;

  modport master (
    output in_valid, in_data, in_signed, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_signed, out_ready,
    output in_ready, out_valid, out_data, out_count, out_zero
  );
endinterface

// File: rtl/norm_unit.sv
// norm_unit: iterative 16-bit normalizer. Shifts the accepted word left one
// bit per cycle until it is normalized (unsigned: MSB set; signed: the two
// top bits differ) and returns the normalized word plus the shift count so a
// later funnel-shifter pass can undo it. A zero input is short-cut straight
// to the result with count 16 (unsigned) or 15 (signed) and out_zero set.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - norm_unit_if.slave (request and result valid/ready handshakes)
module norm_unit (
  input  logic         clk,
  input  logic         rst_n,
  norm_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e      state_q,     state_d;
  logic [15:0] work_q,      work_d;
  logic        sgn_q,       sgn_d;
  logic [4:0]  count_q,     count_d;
  // Result registers are separate from the work register so the visible
  // outputs only move when a result is published.
  logic [15:0] res_data_q,  res_data_d;
  logic [4:0]  res_count_q, res_count_d;
  logic        res_zero_q,  res_zero_d;
  logic        in_ready_q,  in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        norm_s;

  // Normalized test on the current work word for the latched mode.
  always_comb begin
    if (sgn_q) begin
      norm_s = work_q[15] ^ work_q[14];
    end else begin
      norm_s = work_q[15];
    end
  end

  // Next-state, datapath and result-publish logic.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    sgn_d       = sgn_q;
    count_d     = count_q;
    res_data_d  = res_data_q;
    res_count_d = res_count_q;
    res_zero_d  = res_zero_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          sgn_d   = bus.in_signed;
          count_d = 5'd0;
          if (bus.in_data == 16'h0000) begin
            // No bit to find: report full-width shift directly.
            work_d      = 16'h0000;
            res_data_d  = 16'h0000;
            res_count_d = bus.in_signed ? 5'd15 : 5'd16;
            res_zero_d  = 1'b1;
            state_d     = ST_DONE;
          end else begin
            work_d  = bus.in_data;
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (norm_s) begin
          res_data_d  = work_q;
          res_count_d = count_q;
          res_zero_d  = 1'b0;
          state_d     = ST_DONE;
        end else begin
          work_d  = {work_q[14:0], 1'b0};
          count_d = count_q + 5'd1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake outputs are registered decodes of the next state, which
    // makes them identical to decoding the current state one cycle later.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      work_q      <= 16'h0000;
      sgn_q       <= 1'b0;
      count_q     <= 5'd0;
      res_data_q  <= 16'h0000;
      res_count_q <= 5'd0;
      res_zero_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      sgn_q       <= sgn_d;
      count_q     <= count_d;
      res_data_q  <= res_data_d;
      res_count_q <= res_count_d;
      res_zero_q  <= res_zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = res_data_q;
  assign bus.out_count = res_count_q;
  assign bus.out_zero  = res_zero_q;

endmodule

// File: tb/tb_norm_unit.sv
// tb_norm_unit: self-checking bench for norm_unit. Directed corner cases,
// backpressure, mid-operation reset and a randomized run, all compared
// against a leading-bit-count reference model.
module tb_norm_unit;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  norm_unit_if bus_if ();

  norm_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: shift = number of leading bits equal to the reference bit
  // (0 for unsigned, the sign for signed), minus one for signed.
  task automatic ref_norm(input logic [15:0] d, input bit s,
                          output logic [15:0] rd, output int rc, output bit rz);
    int  lead;
    bit  stop;
    bit  rb;
    lead = 0;
    stop = 1'b0;
    rb   = s ? d[15] : 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (!stop && d[i] == rb) lead++;
      else stop = 1'b1;
    end
    if (d == 16'h0000) begin
      rz = 1'b1;
      rd = 16'h0000;
      rc = s ? 15 : 16;
    end else begin
      rz = 1'b0;
      rc = s ? lead - 1 : lead;
      rd = d << rc;
    end
  endtask

  // One full transaction: accept, wait for result, optional stall, consume.
  task automatic do_op(input logic [15:0] d, input bit s, input int stall);
    logic [15:0] ed;
    int          ec;
    bit          ez;
    int          w;
    int          lat;
    ref_norm(d, s, ed, ec, ez);
    w = 0;
    while (!bus_if.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_accept", {31'd0, bus_if.in_ready}, 32'd1);
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = d;
    bus_if.in_signed = s;
    bus_if.out_ready = (stall == 0);
    @(negedge clk);
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = 16'($urandom);
    bus_if.in_signed = 1'($urandom);
    lat = 1;
    while (!bus_if.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_seen", {31'd0, bus_if.out_valid}, 32'd1);
    check("latency", lat, ez ? 32'd1 : 32'(2 + ec));
    check("out_data", {16'd0, bus_if.out_data}, {16'd0, ed});
    check("out_count", {27'd0, bus_if.out_count}, 32'(ec));
    check("out_zero", {31'd0, bus_if.out_zero}, {31'd0, ez});
    check("in_ready_in_done", {31'd0, bus_if.in_ready}, 32'd0);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, bus_if.out_valid}, 32'd1);
      check("hold_data", {16'd0, bus_if.out_data}, {16'd0, ed});
      check("hold_count", {27'd0, bus_if.out_count}, 32'(ec));
      check("hold_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
    end
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    check("consumed_valid_low", {31'd0, bus_if.out_valid}, 32'd0);
    check("in_ready_after_consume", {31'd0, bus_if.in_ready}, 32'd1);
    bus_if.out_ready = 1'($urandom);
  endtask

  initial begin
    int seen;
    logic [15:0] rd;
    n_tests = 0;
    n_fail  = 0;
    rst_n            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = 16'h0000;
    bus_if.in_signed = 1'b0;
    bus_if.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check("rst_out_data", {16'd0, bus_if.out_data}, 32'd0);
    check("rst_out_count", {27'd0, bus_if.out_count}, 32'd0);
    check("rst_out_zero", {31'd0, bus_if.out_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corner cases.
    do_op(16'h8000, 1'b0, 0);
    do_op(16'h0001, 1'b0, 0);
    do_op(16'hFFF0, 1'b1, 0);
    do_op(16'h0003, 1'b1, 0);
    do_op(16'hFFFF, 1'b1, 0);
    do_op(16'h0000, 1'b0, 0);
    do_op(16'h0000, 1'b1, 0);
    do_op(16'h4000, 1'b1, 0);
    // Backpressure followed by back-to-back requests.
    do_op(16'h0100, 1'b0, 5);
    do_op(16'h00F0, 1'b0, 0);
    do_op(16'hC000, 1'b1, 0);

    // Reset in the middle of a shift sequence.
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = 16'h0001;
    bus_if.in_signed = 1'b0;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus_if.out_valid) seen++;
    end
    check("no_stale_result", seen, 32'd0);
    check("idle_after_reset", {31'd0, bus_if.in_ready}, 32'd1);

    // Randomized run: bias toward short words so all shift counts appear.
    for (int n = 0; n < 60; n++) begin
      rd = 16'($urandom) >> $urandom_range(0, 16);
      if ($urandom_range(0, 3) == 0) rd = ~rd;
      if ($urandom_range(0, 15) == 0) rd = 16'h0000;
      do_op(rd, 1'($urandom), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
